// File: rtl/univ_shift_pkg.sv
// Shared mode encoding for the universal shift register and its bit cells.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package univ_shift_pkg;

    typedef logic [2:0] mode_t;

    localparam mode_t MODE_HOLD = 3'b000;
    localparam mode_t MODE_SHR  = 3'b001;
    localparam mode_t MODE_SHL  = 3'b010;
    localparam mode_t MODE_LOAD = 3'b011;
    localparam mode_t MODE_ROR  = 3'b100;
    localparam mode_t MODE_ROL  = 3'b101;
    localparam mode_t MODE_ASR  = 3'b110;
    localparam mode_t MODE_CLR  = 3'b111;

    // True for ops that move bits towards the LSB (bit 0 leaves the register).
    function automatic logic mode_moves_right(input mode_t m);
        return (m == MODE_SHR) || (m == MODE_ROR) || (m == MODE_ASR);
    endfunction

    // True for ops that move bits towards the MSB (top bit leaves the register).
    function automatic logic mode_moves_left(input mode_t m);
        return (m == MODE_SHL) || (m == MODE_ROL);
    endfunction

endpackage

// File: rtl/univ_shift_reg_shift_stage.sv
// One bit of the universal shift register: 8:1 next-state mux plus flop.
// Latency: one cycle from sampled inputs to o_q.
// Backpressure: none; en = 0 holds the bit, rst clears it synchronously.
module shift_stage
    import univ_shift_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  en,
    input  mode_t mode,
    input  logic  i_load,     // parallel load bit for this position
    input  logic  i_shr_bit,  // bit entering on SHR (upper neighbour or sr_in)
    input  logic  i_ror_bit,  // bit entering on ROR (upper neighbour or wrap)
    input  logic  i_asr_bit,  // bit entering on ASR (upper neighbour or sign)
    input  logic  i_shl_bit,  // bit entering on SHL (lower neighbour or sl_in)
    input  logic  i_rol_bit,  // bit entering on ROL (lower neighbour or wrap)
    output logic  o_q
);

    logic r_q;
    logic w_next;

    // Select the next value of this bit from the operation code.
    always_comb begin
        w_next = r_q;
        case (mode)
            MODE_HOLD: w_next = r_q;
            MODE_SHR:  w_next = i_shr_bit;
            MODE_SHL:  w_next = i_shl_bit;
            MODE_LOAD: w_next = i_load;
            MODE_ROR:  w_next = i_ror_bit;
            MODE_ROL:  w_next = i_rol_bit;
            MODE_ASR:  w_next = i_asr_bit;
            MODE_CLR:  w_next = 1'b0;
            default:   w_next = r_q;
        endcase
    end

    // Storage flop: reset beats enable, enable gates the mux result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= 1'b0;
        end else if (en) begin
            r_q <= w_next;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/univ_shift_reg.sv
// Universal WIDTH-bit shift register (hold/shift/load/rotate/asr/clear) with registered shift-out.
// Latency: one cycle; A and shout update on the edge that samples the op.
// Backpressure: none; an op can be issued every cycle, en = 0 freezes all state.
module univ_shift_reg
    import univ_shift_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] I,
    input  logic             sr_in,
    input  logic             sl_in,
    output logic [WIDTH-1:0] A,
    output logic             shout
);

    logic [WIDTH-1:0] w_q;
    logic             r_shout;
    mode_t            w_mode;

    assign w_mode = mode_t'(mode);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic w_from_hi_shr;
            logic w_from_hi_ror;
            logic w_from_hi_asr;
            logic w_from_lo_shl;
            logic w_from_lo_rol;

            // Top cell: serial-in, wrap from bit 0, or sign replication.
            if (gi == WIDTH - 1) begin : g_top
                assign w_from_hi_shr = sr_in;
                assign w_from_hi_ror = w_q[0];
                assign w_from_hi_asr = w_q[WIDTH-1];
            end else begin : g_mid_hi
                assign w_from_hi_shr = w_q[gi+1];
                assign w_from_hi_ror = w_q[gi+1];
                assign w_from_hi_asr = w_q[gi+1];
            end

            // Bottom cell: serial-in or wrap from the MSB.
            if (gi == 0) begin : g_bot
                assign w_from_lo_shl = sl_in;
                assign w_from_lo_rol = w_q[WIDTH-1];
            end else begin : g_mid_lo
                assign w_from_lo_shl = w_q[gi-1];
                assign w_from_lo_rol = w_q[gi-1];
            end

            shift_stage u_stage (
                .clk       (clk),
                .rst       (rst),
                .en        (en),
                .mode      (w_mode),
                .i_load    (I[gi]),
                .i_shr_bit (w_from_hi_shr),
                .i_ror_bit (w_from_hi_ror),
                .i_asr_bit (w_from_hi_asr),
                .i_shl_bit (w_from_lo_shl),
                .i_rol_bit (w_from_lo_rol),
                .o_q       (w_q[gi])
            );
        end
    endgenerate

    // Shift-out bit: captures whichever end bit leaves the register; CLR zeroes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shout <= 1'b0;
        end else if (en) begin
            if (mode_moves_right(w_mode)) begin
                r_shout <= w_q[0];
            end else if (mode_moves_left(w_mode)) begin
                r_shout <= w_q[WIDTH-1];
            end else if (w_mode == MODE_CLR) begin
                r_shout <= 1'b0;
            end
        end
    end

    assign A     = w_q;
    assign shout = r_shout;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Bench for univ_shift_reg at WIDTH = 4 and WIDTH = 8.
// Latency: checks one cycle after each sampling edge.
// Backpressure: n/a.
module tb_univ_shift_reg;

    logic       clk = 1'b0;
    logic       rst, en, sr_in, sl_in;
    logic [2:0] mode;
    logic [3:0] i4;
    logic [7:0] i8;
    logic [3:0] a4;
    logic [7:0] a8;
    logic       sh4, sh8;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    univ_shift_reg #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .I(i4),
        .sr_in(sr_in), .sl_in(sl_in), .A(a4), .shout(sh4)
    );

    univ_shift_reg #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .I(i8),
        .sr_in(sr_in), .sl_in(sl_in), .A(a8), .shout(sh8)
    );

    localparam logic [2:0] HOLD = 3'd0, SHR = 3'd1, SHL = 3'd2, LOAD = 3'd3,
                           ROR  = 3'd4, ROL = 3'd5, ASR = 3'd6, CLR  = 3'd7;

    typedef struct {
        logic       rst;
        logic       en;
        logic [2:0] mode;
        logic [3:0] din;
        logic       sr;
        logic       sl;
        logic [3:0] exp_a;
        logic       exp_sh;
    } vec_t;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drive one op away from the edge, let it be sampled, settle past the edge.
    task automatic apply(input logic r, input logic e, input logic [2:0] m,
                         input logic [3:0] d4, input logic [7:0] d8,
                         input logic s_r, input logic s_l);
        @(negedge clk);
        rst = r; en = e; mode = m; i4 = d4; i8 = d8; sr_in = s_r; sl_in = s_l;
        @(posedge clk);
        #1;
    endtask

    // Reference: next register value from the op rules, using shifts and masks.
    function automatic logic [8:0] model_next(input int w, input logic [7:0] a, input logic sh,
                                              input logic r, input logic e, input logic [2:0] m,
                                              input logic [7:0] d, input logic s_r, input logic s_l);
        logic [7:0] mask, na;
        logic       lsb, msb, nsh;
        mask = 8'((9'd1 << w) - 9'd1);
        lsb  = a[0];
        msb  = 1'((a >> (w - 1)) & 8'd1);
        na   = a;
        nsh  = sh;
        if (r) begin
            na = 8'd0; nsh = 1'b0;
        end else if (e) begin
            case (m)
                SHR:  begin na = (a >> 1) | (8'(s_r) << (w - 1)); nsh = lsb; end
                SHL:  begin na = ((a << 1) | 8'(s_l)) & mask;     nsh = msb; end
                LOAD: na = d & mask;
                ROR:  begin na = (a >> 1) | (8'(lsb) << (w - 1)); nsh = lsb; end
                ROL:  begin na = ((a << 1) | 8'(msb)) & mask;     nsh = msb; end
                ASR:  begin na = (a >> 1) | (8'(msb) << (w - 1)); nsh = lsb; end
                CLR:  begin na = 8'd0; nsh = 1'b0; end
                default: ;
            endcase
        end
        return {nsh, na};
    endfunction

    vec_t vecs[$];

    initial begin
        logic [7:0] m4, m8;
        logic       ms4, ms8;
        logic [8:0] nx;

        rst = 1'b0; en = 1'b0; mode = HOLD; i4 = '0; i8 = '0; sr_in = 1'b0; sl_in = 1'b0;

        //            rst  en  mode  din     sr  sl  exp_a    exp_sh
        vecs.push_back('{1, 1, LOAD, 4'b1111, 0, 0, 4'b0000, 0}); // reset wins over load
        vecs.push_back('{0, 1, LOAD, 4'b1010, 0, 0, 4'b1010, 0});
        vecs.push_back('{0, 1, LOAD, 4'b1011, 0, 0, 4'b1011, 0});
        vecs.push_back('{0, 1, SHR,  4'b0000, 0, 1, 4'b0101, 1});
        vecs.push_back('{0, 1, SHL,  4'b0000, 0, 1, 4'b1011, 0});
        vecs.push_back('{0, 1, LOAD, 4'b1001, 1, 1, 4'b1001, 0});
        vecs.push_back('{0, 1, ROL,  4'b0000, 0, 0, 4'b0011, 1});
        vecs.push_back('{0, 1, ROL,  4'b1111, 0, 0, 4'b0110, 0});
        vecs.push_back('{0, 1, ROL,  4'b0000, 1, 0, 4'b1100, 0});
        vecs.push_back('{0, 1, ROL,  4'b0000, 0, 1, 4'b1001, 1}); // wrapped back to start
        vecs.push_back('{0, 1, LOAD, 4'b1000, 0, 0, 4'b1000, 1}); // load keeps shout
        vecs.push_back('{0, 1, ASR,  4'b0000, 0, 0, 4'b1100, 0});
        vecs.push_back('{0, 1, ASR,  4'b0000, 0, 0, 4'b1110, 0});
        vecs.push_back('{0, 1, CLR,  4'b1111, 1, 1, 4'b0000, 0});
        vecs.push_back('{0, 1, LOAD, 4'b0011, 0, 0, 4'b0011, 0});
        vecs.push_back('{0, 1, ROR,  4'b0000, 0, 0, 4'b1001, 1});
        vecs.push_back('{0, 1, LOAD, 4'b0110, 0, 0, 4'b0110, 1});
        vecs.push_back('{0, 0, CLR,  4'b0000, 1, 1, 4'b0110, 1}); // en = 0 ignores CLR
        vecs.push_back('{0, 1, HOLD, 4'b1111, 1, 1, 4'b0110, 1});
        vecs.push_back('{1, 0, CLR,  4'b1111, 0, 0, 4'b0000, 0}); // reset beats en = 0
        vecs.push_back('{0, 1, LOAD, 4'b0101, 0, 0, 4'b0101, 0});
        vecs.push_back('{0, 1, ROR,  4'b0000, 0, 0, 4'b1010, 1});
        vecs.push_back('{0, 1, ROR,  4'b0000, 0, 0, 4'b0101, 0});
        vecs.push_back('{0, 1, ASR,  4'b0000, 0, 0, 4'b0010, 1});
        vecs.push_back('{0, 1, SHR,  4'b0000, 1, 0, 4'b1001, 0});

        for (int k = 0; k < vecs.size(); k++) begin
            apply(vecs[k].rst, vecs[k].en, vecs[k].mode, vecs[k].din, 8'h00,
                  vecs[k].sr, vecs[k].sl);
            check($sformatf("vec%0d A", k), {4'h0, a4}, {4'h0, vecs[k].exp_a});
            check($sformatf("vec%0d shout", k), {7'h0, sh4}, {7'h0, vecs[k].exp_sh});
        end

        // Mode changes between edges must not disturb A.
        apply(0, 1, LOAD, 4'b1100, 8'h00, 0, 0);
        @(negedge clk);
        mode = CLR; en = 1'b0;
        #2 mode = SHL;
        #1 check("stable between edges", {4'h0, a4}, 8'h0C);

        // WIDTH = 8: load then rotate right, then a full wrap of 8 rotates.
        apply(1, 0, HOLD, 4'h0, 8'h00, 0, 0);
        check("w8 reset A", a8, 8'h00);
        apply(0, 1, LOAD, 4'h0, 8'h81, 0, 0);
        check("w8 load", a8, 8'h81);
        apply(0, 1, ROR, 4'h0, 8'h00, 0, 0);
        check("w8 ror A", a8, 8'hC0);
        check("w8 ror shout", {7'h0, sh8}, 8'h01);
        for (int k = 0; k < 8; k++) apply(0, 1, ROR, 4'h0, 8'h00, 0, 0);
        check("w8 ror wrap", a8, 8'hC0);

        // Random ops against the reference model; first cycle resets to sync.
        m4 = '0; ms4 = 1'b0; m8 = '0; ms8 = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            logic       r, e, s_r, s_l;
            logic [2:0] m;
            logic [3:0] d4;
            logic [7:0] d8;
            r   = (k == 0) || ($urandom_range(0, 31) == 0);
            e   = ($urandom_range(0, 3) != 0);
            m   = 3'($urandom_range(0, 7));
            d4  = 4'($urandom);
            d8  = 8'($urandom);
            s_r = 1'($urandom);
            s_l = 1'($urandom);
            apply(r, e, m, d4, d8, s_r, s_l);
            nx  = model_next(4, m4, ms4, r, e, m, {4'h0, d4}, s_r, s_l);
            m4  = nx[7:0]; ms4 = nx[8];
            nx  = model_next(8, m8, ms8, r, e, m, d8, s_r, s_l);
            m8  = nx[7:0]; ms8 = nx[8];
            check("rand w4 A", {4'h0, a4}, m4);
            check("rand w4 shout", {7'h0, sh4}, {7'h0, ms4});
            check("rand w8 A", a8, m8);
            check("rand w8 shout", {7'h0, sh8}, {7'h0, ms8});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
